// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port arbiter: round-robin sharing of the RAM write port
// among paddle, ball and score requesters, plus a full-frame clear sequencer.
module fb_write_arbiter #(
  parameter int AW      = 15,
  parameter int DW      = 3,
  parameter int FB_SIZE = 21120
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    req,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] data0,
  input  logic [DW-1:0] data1,
  input  logic [DW-1:0] data2,
  output logic [2:0]    gnt,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_color,
  output logic          clr_busy,
  output logic          clr_done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_we
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(FB_SIZE - 1);

  typedef enum logic {ARB, CLEAR} state_t;

  state_t        state_q, state_d;
  logic [2:0]    gnt_q, gnt_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_data_q, mem_data_d;
  logic          clr_busy_q, clr_busy_d;
  logic          clr_done_q, clr_done_d;
  logic [1:0]    last_q, last_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] color_q, color_d;

  logic [2:0]    eligible;
  logic [1:0]    first, second, third, pick;

  // Round-robin pick: scan eligible requesters starting after the last winner,
  // masking last cycle's winner so every grant gets a turnaround cycle.
  always_comb begin
    eligible = req & ~gnt_q;
    case (last_q)
      2'd0:    begin first = 2'd1; second = 2'd2; third = 2'd0; end
      2'd1:    begin first = 2'd2; second = 2'd0; third = 2'd1; end
      default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
    endcase
    if (eligible[first])       pick = first;
    else if (eligible[second]) pick = second;
    else                       pick = third;
  end

  // Next-state logic for arbitration and the clear sweep.
  always_comb begin
    state_d    = state_q;
    gnt_d      = 3'b000;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    clr_busy_d = 1'b0;
    clr_done_d = 1'b0;
    last_d     = last_q;
    cnt_d      = cnt_q;
    color_d    = color_q;
    case (state_q)
      ARB: begin
        if (clr_start) begin
          state_d = CLEAR;
          color_d = clr_color;
          cnt_d   = '0;
        end else if (eligible != 3'b000) begin
          gnt_d    = 3'b001 << pick;
          mem_we_d = 1'b1;
          last_d   = pick;
          case (pick)
            2'd0:    begin mem_addr_d = addr0; mem_data_d = data0; end
            2'd1:    begin mem_addr_d = addr1; mem_data_d = data1; end
            default: begin mem_addr_d = addr2; mem_data_d = data2; end
          endcase
        end
      end
      CLEAR: begin
        if (clr_busy_q && (mem_addr_q == LAST_ADDR)) begin
          state_d    = ARB;
          clr_done_d = 1'b1;
        end else begin
          mem_we_d   = 1'b1;
          clr_busy_d = 1'b1;
          mem_addr_d = cnt_q;
          mem_data_d = color_q;
          if (cnt_q != LAST_ADDR) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // State and registered outputs; reset leaves requester 0 first in line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB;
      gnt_q      <= 3'b000;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
      last_q     <= 2'd2;
      cnt_q      <= '0;
      color_q    <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      color_q    <= color_d;
    end
  end

  assign gnt      = gnt_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed testbench for fb_write_arbiter: arbitration, clear sweep, reset.
module tb_fb_write_arbiter;

  localparam int AW      = 15;
  localparam int DW      = 3;
  localparam int FB_SIZE = 21120;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    req;
  logic [AW-1:0] addr0, addr1, addr2;
  logic [DW-1:0] data0, data1, data2;
  logic [2:0]    gnt;
  logic          clr_start;
  logic [DW-1:0] clr_color;
  logic          clr_busy, clr_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_we;

  int total_cnt = 0;
  int pass_cnt  = 0;

  fb_write_arbiter #(.AW(AW), .DW(DW), .FB_SIZE(FB_SIZE)) dut (
    .clk(clk), .rst(rst), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .data0(data0), .data1(data1), .data2(data2),
    .gnt(gnt), .clr_start(clr_start), .clr_color(clr_color),
    .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we)
  );

  // Free-running game clock.
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    req = 3'b000;
    clr_start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 3'b000; clr_start = 1'b0; clr_color = '0;
    addr0 = '0; addr1 = '0; addr2 = '0;
    data0 = '0; data1 = '0; data2 = '0;
    @(negedge clk);
    total_cnt++;
    if ({gnt, mem_we, clr_busy, clr_done} !== 6'b0)
      $display("[TB] FAIL reset_ctrl: got %b expected 000000", {gnt, mem_we, clr_busy, clr_done});
    else pass_cnt++;
    total_cnt++;
    if ({mem_addr, mem_data} !== '0)
      $display("[TB] FAIL reset_mem: got addr %0d data %0d expected 0 0", mem_addr, mem_data);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({gnt, mem_we, clr_busy} !== 5'b0)
      $display("[TB] FAIL idle_after_reset: got %b expected 00000", {gnt, mem_we, clr_busy});
    else pass_cnt++;
  endtask

  task automatic test_single();
    req = 3'b001; addr0 = 15'd100; data0 = 3'b100;
    @(negedge clk);
    total_cnt++;
    if (gnt !== 3'b001) $display("[TB] FAIL single_gnt: got %b expected 001", gnt);
    else pass_cnt++;
    total_cnt++;
    if (mem_we !== 1'b1) $display("[TB] FAIL single_we: got %b expected 1", mem_we);
    else pass_cnt++;
    total_cnt++;
    if (mem_addr !== 15'd100) $display("[TB] FAIL single_addr: got %0d expected 100", mem_addr);
    else pass_cnt++;
    total_cnt++;
    if (mem_data !== 3'b100) $display("[TB] FAIL single_data: got %b expected 100", mem_data);
    else pass_cnt++;
    req = 3'b000;
    @(negedge clk);
    total_cnt++;
    if ({gnt, mem_we} !== 4'b0000) $display("[TB] FAIL single_drop: got %b expected 0000", {gnt, mem_we});
    else pass_cnt++;
    total_cnt++;
    if (mem_addr !== 15'd100) $display("[TB] FAIL single_hold_addr: got %0d expected 100", mem_addr);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [2:0]    exp_g [6];
    logic [AW-1:0] exp_a [6];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_a = '{15'd10, 15'd20, 15'd30, 15'd10, 15'd20, 15'd30};
    do_reset();
    addr0 = 15'd10; addr1 = 15'd20; addr2 = 15'd30;
    data0 = 3'd1; data1 = 3'd2; data2 = 3'd3;
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total_cnt++;
      if (gnt !== exp_g[k]) $display("[TB] FAIL rr_gnt[%0d]: got %b expected %b", k, gnt, exp_g[k]);
      else pass_cnt++;
      total_cnt++;
      if (mem_we !== 1'b1 || mem_addr !== exp_a[k])
        $display("[TB] FAIL rr_write[%0d]: got we %b addr %0d expected we 1 addr %0d", k, mem_we, mem_addr, exp_a[k]);
      else pass_cnt++;
    end
    req = 3'b000;
    @(negedge clk);
  endtask

  task automatic test_single_requester();
    logic [2:0] exp_g;
    do_reset();
    addr1 = 15'd55; data1 = 3'd6;
    req = 3'b010;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_g = (k % 2 == 0) ? 3'b010 : 3'b000;
      total_cnt++;
      if (gnt !== exp_g || mem_we !== exp_g[1])
        $display("[TB] FAIL solo_gnt[%0d]: got gnt %b we %b expected gnt %b we %b", k, gnt, mem_we, exp_g, exp_g[1]);
      else pass_cnt++;
    end
    total_cnt++;
    if (mem_addr !== 15'd55 || mem_data !== 3'd6)
      $display("[TB] FAIL solo_write: got addr %0d data %0d expected 55 6", mem_addr, mem_data);
    else pass_cnt++;
    req = 3'b000;
    @(negedge clk);
  endtask

  task automatic test_clear();
    int busy_cycles, errs, exp_addr;
    bit seen_done;
    busy_cycles = 0; errs = 0; exp_addr = 0; seen_done = 0;
    req = 3'b000;
    clr_color = 3'b010;
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    total_cnt++;
    if ({gnt, mem_we, clr_busy} !== 5'b0)
      $display("[TB] FAIL clear_start_cycle: got %b expected 00000", {gnt, mem_we, clr_busy});
    else pass_cnt++;
    for (int c = 0; c < FB_SIZE + 100 && !seen_done; c++) begin
      @(negedge clk);
      if (clr_busy) begin
        if (mem_we !== 1'b1 || int'(mem_addr) != exp_addr || mem_data !== 3'b010) begin
          if (errs == 0)
            $display("[TB] clear write error at %0d: we %b addr %0d data %b", exp_addr, mem_we, mem_addr, mem_data);
          errs++;
        end
        exp_addr++;
        busy_cycles++;
      end
      if (clr_done) begin
        seen_done = 1;
        if (mem_we !== 1'b0 || clr_busy !== 1'b0) errs++;
      end
      if (gnt !== 3'b000) errs++;
    end
    total_cnt++;
    if (!seen_done) $display("[TB] FAIL clear_done_seen: got no clr_done expected one within budget");
    else pass_cnt++;
    total_cnt++;
    if (busy_cycles != FB_SIZE) $display("[TB] FAIL clear_busy_len: got %0d expected %0d", busy_cycles, FB_SIZE);
    else pass_cnt++;
    total_cnt++;
    if (errs != 0) $display("[TB] FAIL clear_writes: got %0d bad cycles expected 0", errs);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({clr_done, mem_we, clr_busy} !== 3'b000)
      $display("[TB] FAIL clear_after: got done/we/busy %b expected 000", {clr_done, mem_we, clr_busy});
    else pass_cnt++;
  endtask

  task automatic test_clear_with_req();
    int busy_cycles, gnt_errs, data_errs;
    bit seen_done;
    busy_cycles = 0; gnt_errs = 0; data_errs = 0; seen_done = 0;
    req = 3'b000;
    clr_color = 3'b101;
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    for (int c = 0; c < FB_SIZE + 100 && !seen_done; c++) begin
      @(negedge clk);
      if (clr_busy) begin
        busy_cycles++;
        if (mem_data !== 3'b101) data_errs++;
      end
      if (gnt !== 3'b000) gnt_errs++;
      if (clr_done) seen_done = 1;
      if (c == 500) begin
        req = 3'b100; addr2 = 15'd7; data2 = 3'd3;
      end
      if (c == 1000) clr_color = 3'b001;
      clr_start = (c == 2000);
    end
    clr_start = 1'b0;
    total_cnt++;
    if (!seen_done) $display("[TB] FAIL clrreq_done_seen: got no clr_done expected one within budget");
    else pass_cnt++;
    total_cnt++;
    if (busy_cycles != FB_SIZE) $display("[TB] FAIL clrreq_busy_len: got %0d expected %0d", busy_cycles, FB_SIZE);
    else pass_cnt++;
    total_cnt++;
    if (gnt_errs != 0) $display("[TB] FAIL clrreq_no_gnt: got %0d grant cycles expected 0", gnt_errs);
    else pass_cnt++;
    total_cnt++;
    if (data_errs != 0) $display("[TB] FAIL clrreq_color: got %0d bad colour cycles expected 0", data_errs);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (gnt !== 3'b100 || mem_we !== 1'b1)
      $display("[TB] FAIL clrreq_gnt: got gnt %b we %b expected 100 1", gnt, mem_we);
    else pass_cnt++;
    total_cnt++;
    if (mem_addr !== 15'd7 || mem_data !== 3'd3)
      $display("[TB] FAIL clrreq_write: got addr %0d data %0d expected 7 3", mem_addr, mem_data);
    else pass_cnt++;
    req = 3'b000;
    @(negedge clk);
    total_cnt++;
    if (gnt !== 3'b000) $display("[TB] FAIL clrreq_release: got %b expected 000", gnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_clear();
    bit found;
    found = 0;
    clr_color = 3'b110;
    req = 3'b001; addr0 = 15'd9; data0 = 3'd1;
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    total_cnt++;
    if ({gnt, mem_we} !== 4'b0000)
      $display("[TB] FAIL clear_beats_req: got gnt/we %b expected 0000", {gnt, mem_we});
    else pass_cnt++;
    for (int c = 0; c < 1200 && !found; c++) begin
      @(negedge clk);
      if (clr_busy === 1'b1 && mem_addr === 15'd1000) found = 1;
    end
    total_cnt++;
    if (!found) $display("[TB] FAIL mid_reach_1000: got no address 1000 expected it within budget");
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({gnt, mem_we, clr_busy, clr_done, mem_addr, mem_data} !== '0)
      $display("[TB] FAIL async_reset: got addr %0d we %b busy %b expected all zero", mem_addr, mem_we, clr_busy);
    else pass_cnt++;
    @(negedge clk);
    req = 3'b000;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({mem_we, clr_busy} !== 2'b00)
      $display("[TB] FAIL no_resume: got we/busy %b expected 00", {mem_we, clr_busy});
    else pass_cnt++;
    clr_color = 3'b011;
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total_cnt++;
      if (clr_busy !== 1'b1 || int'(mem_addr) != k || mem_data !== 3'b011)
        $display("[TB] FAIL restart[%0d]: got busy %b addr %0d data %b expected 1 %0d 011", k, clr_busy, mem_addr, mem_data, k);
      else pass_cnt++;
    end
    do_reset();
  endtask

  // Directed test sequence, followed by the summary line.
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_single_requester();
    test_clear();
    test_clear_with_req();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Watchdog so a stuck design cannot hang the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
